// File: rtl/heartbeat_sequencer.sv
// heartbeat_sequencer: lub-dub heartbeat animation for the 4-digit seven-segment scan driver.
// Ports: clk, reset (sync, active-high), enable, digit0..digit3 [1:0] codes, beat pulse on P0 entry. Macro: HEARTBEAT_REST_PHASE_EN.
module heartbeat_sequencer #(
  parameter int unsigned TICK_DIV    = 1_388_889,
  parameter int unsigned TICK_W      = 21,
  parameter int unsigned PHASE_TICKS = 1,
  parameter int unsigned REST_TICKS  = 36
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [1:0] digit0,
  output logic [1:0] digit1,
  output logic [1:0] digit2,
  output logic [1:0] digit3,
  output logic       beat
);

  if (TICK_DIV < 1 || PHASE_TICKS < 1 || PHASE_TICKS > 255 ||
      REST_TICKS < 1 || REST_TICKS > 255 ||
      (TICK_W < 32 && (64'(1) << TICK_W) < 64'(TICK_DIV)))
  begin : g_bad_cfg
    $error("heartbeat_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_P0,
    S_P1,
    S_P2,
    S_P3
`ifdef HEARTBEAT_REST_PHASE_EN
    , S_REST
`endif
  } state_t;

  localparam logic [1:0] C_BLANK = 2'd0;
  localparam logic [1:0] C_LEFT  = 2'd1;
  localparam logic [1:0] C_RIGHT = 2'd2;

  localparam logic [TICK_W-1:0] TickLast =
    TICK_W'(TICK_DIV - 1);
  localparam logic [7:0] PhaseLast =
    8'(PHASE_TICKS - 1);
`ifdef HEARTBEAT_REST_PHASE_EN
  localparam logic [7:0] RestLast =
    8'(REST_TICKS - 1);
`endif

  state_t            state_q;
  state_t            state_d;
  logic [TICK_W-1:0] presc_q;
  logic [7:0]        dwell_q;
  logic [7:0]        dwell_last;
  logic              tick;
  logic              expire;

  // {digit3, digit2, digit1, digit0}
  function automatic logic [7:0] pattern(
    input state_t s
  );
    logic [7:0] p;
    p = {4{C_BLANK}};
    unique case (s)
      S_P0:    p = {C_BLANK, C_RIGHT, C_LEFT, C_BLANK};
      S_P1:    p = {C_BLANK, C_LEFT, C_RIGHT, C_BLANK};
      S_P2:    p = {C_RIGHT, C_BLANK, C_BLANK, C_LEFT};
      S_P3:    p = {C_LEFT, C_BLANK, C_BLANK, C_RIGHT};
      default: p = {4{C_BLANK}};
    endcase
    return p;
  endfunction

  always_comb begin
    tick = (presc_q == TickLast);
    dwell_last = PhaseLast;
`ifdef HEARTBEAT_REST_PHASE_EN
    if (state_q == S_REST) dwell_last = RestLast;
`endif
    expire = tick && (dwell_q == dwell_last);
  end

  // Disable wins over any tick-driven move.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_P0;
        S_P0:   if (expire) state_d = S_P1;
        S_P1:   if (expire) state_d = S_P2;
        S_P2:   if (expire) state_d = S_P3;
`ifdef HEARTBEAT_REST_PHASE_EN
        S_P3:   if (expire) state_d = S_REST;
        S_REST: if (expire) state_d = S_P0;
`else
        S_P3:   if (expire) state_d = S_P0;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they
  // switch in the same cycle as the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      dwell_q <= '0;
      digit0  <= C_BLANK;
      digit1  <= C_BLANK;
      digit2  <= C_BLANK;
      digit3  <= C_BLANK;
      beat    <= 1'b0;
    end else begin
      state_q <= state_d;
      {digit3, digit2, digit1, digit0} <= pattern(state_d);
      beat <= (state_d == S_P0) && (state_q != S_P0);
      if (state_d != state_q || state_d == S_IDLE) begin
        presc_q <= '0;
        dwell_q <= '0;
      end else if (tick) begin
        presc_q <= '0;
        dwell_q <= dwell_q + 8'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_heartbeat_sequencer.sv
// tb_heartbeat_sequencer: directed scoreboard bench for heartbeat_sequencer.
// DUT a: TICK_DIV=4 PHASE=2 REST=3; DUT b: all ones.
`timescale 1ns/1ps
module tb_heartbeat_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, enable_a, a_beat;
  logic [1:0] a_d0, a_d1, a_d2, a_d3;
  logic       reset_b, enable_b, b_beat;
  logic [1:0] b_d0, b_d1, b_d2, b_d3;

  heartbeat_sequencer #(
    .TICK_DIV(4), .TICK_W(3),
    .PHASE_TICKS(2), .REST_TICKS(3)
  ) u_a (
    .clk(clk), .reset(reset_a), .enable(enable_a),
    .digit0(a_d0), .digit1(a_d1),
    .digit2(a_d2), .digit3(a_d3),
    .beat(a_beat)
  );

  heartbeat_sequencer #(
    .TICK_DIV(1), .TICK_W(1),
    .PHASE_TICKS(1), .REST_TICKS(1)
  ) u_b (
    .clk(clk), .reset(reset_b), .enable(enable_b),
    .digit0(b_d0), .digit1(b_d1),
    .digit2(b_d2), .digit3(b_d3),
    .beat(b_beat)
  );

  localparam logic [7:0] PAT_IDLE = 8'h00;
  localparam logic [7:0] PAT_P0   = 8'h24;
  localparam logic [7:0] PAT_P1   = 8'h18;
  localparam logic [7:0] PAT_P2   = 8'h81;
  localparam logic [7:0] PAT_P3   = 8'h42;
  localparam logic [7:0] PAT_REST = 8'h00;

  typedef struct {
    string      tag;
    logic [7:0] pat;
    logic       beat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int fails  = 0;

  task automatic cmp(input string dut, input exp_t e,
                     input logic [7:0] pat, input logic b);
    checks++;
    if (pat !== e.pat || b !== e.beat) begin
      fails++;
      $display("FAIL %s/%s t=%0t: got digits=%h beat=%b, want digits=%h beat=%b",
               dut, e.tag, $time, pat, b, e.pat, e.beat);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      cmp("a", e, {a_d3, a_d2, a_d1, a_d0}, a_beat);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      cmp("b", e, {b_d3, b_d2, b_d1, b_d0}, b_beat);
    end
  end

  // Queue the expectation for the current cycle, then
  // advance; inputs set before the call hit the next edge.
  task automatic chk(input bit sel, input string tag,
                     input logic [7:0] p, input logic b);
    exp_t e;
    e.tag = tag;
    e.pat = p;
    e.beat = b;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic phase(input bit sel, input string tag,
                       input logic [7:0] p, input int n,
                       input logic first_beat);
    for (int i = 0; i < n; i++)
      chk(sel, tag, p, (i == 0) ? first_beat : 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_a = 1'b1;
    enable_a = 1'b0;
    reset_b = 1'b1;
    enable_b = 1'b0;
    @(posedge clk);
    #1;
    reset_a = 1'b0;

    phase(0, "idle_hold", PAT_IDLE, 50, 1'b0);

    enable_a = 1'b1;
    chk(0, "en_rise", PAT_IDLE, 1'b0);
    phase(0, "p0", PAT_P0, 8, 1'b1);
    phase(0, "p1", PAT_P1, 8, 1'b0);
    phase(0, "p2", PAT_P2, 8, 1'b0);
    phase(0, "p3", PAT_P3, 8, 1'b0);
`ifdef HEARTBEAT_REST_PHASE_EN
    phase(0, "rest", PAT_REST, 12, 1'b0);
`endif
    phase(0, "p0_next", PAT_P0, 8, 1'b1);
    phase(0, "p1_next", PAT_P1, 8, 1'b0);
    phase(0, "p2_pre_drop", PAT_P2, 4, 1'b0);

    enable_a = 1'b0;
    chk(0, "p2_drop", PAT_P2, 1'b0);
    phase(0, "idle_drop", PAT_IDLE, 3, 1'b0);
    enable_a = 1'b1;
    chk(0, "idle_reen", PAT_IDLE, 1'b0);
    phase(0, "p0_reen", PAT_P0, 8, 1'b1);
    phase(0, "p1_pre_exp", PAT_P1, 7, 1'b0);

    enable_a = 1'b0;
    chk(0, "p1_exp_drop", PAT_P1, 1'b0);
    phase(0, "idle_exp", PAT_IDLE, 2, 1'b0);
    enable_a = 1'b1;
    chk(0, "idle_reen2", PAT_IDLE, 1'b0);
    phase(0, "p0_r", PAT_P0, 8, 1'b1);
    phase(0, "p1_pre_rst", PAT_P1, 3, 1'b0);

    reset_a = 1'b1;
    chk(0, "p1_rst", PAT_P1, 1'b0);
    reset_a = 1'b0;
    chk(0, "rst_vals", PAT_IDLE, 1'b0);
    phase(0, "p0_post_rst", PAT_P0, 8, 1'b1);
    phase(0, "p1_post_rst", PAT_P1, 2, 1'b0);

    reset_b = 1'b0;
    enable_b = 1'b1;
    chk(1, "b_en", PAT_IDLE, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk(1, "b_p0", PAT_P0, 1'b1);
      chk(1, "b_p1", PAT_P1, 1'b0);
      chk(1, "b_p2", PAT_P2, 1'b0);
      chk(1, "b_p3", PAT_P3, 1'b0);
`ifdef HEARTBEAT_REST_PHASE_EN
      chk(1, "b_rest", PAT_REST, 1'b0);
`endif
    end
    chk(1, "b_p0_last", PAT_P0, 1'b1);
    enable_b = 1'b0;
    chk(1, "b_p1_drop", PAT_P1, 1'b0);
    phase(1, "b_idle", PAT_IDLE, 3, 1'b0);

    @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0",
               qa.size(), qb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
